// File: rtl/approx_mul_pkg.sv
// Shared types and default widths for the approximate-multiplier accumulation stage.
package approx_mul_pkg;

  localparam int PROD_W_DEF = 16;
  localparam int ACC_W_DEF  = 24;
  localparam int LEN_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// Combinational accumulator + product adder; clamps to all-ones on carry-out
// when built with ACC_SAT_EN.
module acc_sat_add
  import approx_mul_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] full;

  assign full  = {1'b0, acc} + (ACC_W+1)'(prod);
  assign carry = full[ACC_W];

`ifdef ACC_SAT_EN
  // Once clamped, any further nonzero product carries again, so max is sticky.
  assign sum = carry ? '1 : full[ACC_W-1:0];
`else
  assign sum = full[ACC_W-1:0];
`endif

endmodule

// File: rtl/approx_mul_acc.sv
// Block accumulator for the approximate multiplier product stream.
// Optional saturating arithmetic is enabled with the ACC_SAT_EN macro.
module approx_mul_acc
  import approx_mul_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] prod_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_o,
  output logic [LEN_W-1:0]  cnt_o,
  output logic              sat_o
);

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [LEN_W-1:0]  cnt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_nxt;
  logic [LEN_W-1:0]  len_eff;
  logic [ACC_W-1:0]  sum;
  logic              carry;

  acc_sat_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .acc   (acc),
    .prod  (prod_i),
    .sum   (sum),
    .carry (carry)
  );

  assign cnt_nxt = cnt + LEN_W'(1);
  assign len_eff = (len_i == '0) ? LEN_W'(1) : len_i;

  // Handshake flags come from state only; rst masks ready while held.
  assign in_ready  = !rst && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign acc_o     = acc;
  assign cnt_o     = cnt;

`ifdef ACC_SAT_EN
  logic sat;
  assign sat_o = sat;
`else
  logic unused_carry;
  assign unused_carry = carry;
  assign sat_o        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
      len_q <= '0;
`ifdef ACC_SAT_EN
      sat   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          len_q <= len_eff;
          acc   <= ACC_W'(prod_i);
          cnt   <= LEN_W'(1);
`ifdef ACC_SAT_EN
          sat   <= 1'b0;
`endif
          state <= (len_eff == LEN_W'(1)) ? HOLD : ACCUM;
        end
        ACCUM: if (in_valid) begin
          acc <= sum;
          cnt <= cnt_nxt;
`ifdef ACC_SAT_EN
          sat <= sat | carry;
`endif
          if (cnt_nxt == len_q) state <= HOLD;
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_mul_acc.sv
// Self-checking bench for approx_mul_acc: directed scenarios plus randomized blocks
// checked against a sum-of-products reference (wrapping or clamping with ACC_SAT_EN).
module tb_approx_mul_acc;

  localparam int PW = 16;
  localparam int AW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [LW-1:0] len_i = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] prod_i = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] acc_o;
  logic [LW-1:0] cnt_o;
  logic          sat_o;

  int checks   = 0;
  int failures = 0;
  int unsigned prods[$];

  approx_mul_acc #(.PROD_W(PW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .len_i     (len_i),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_i    (prod_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_o     (acc_o),
    .cnt_o     (cnt_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feeds prods[0..n-1] as one block, then drains it after `stall` refused cycles.
  task automatic run_block(input int len, input bit gapped, input int stall);
    int n;
    longint total;
    logic [31:0] e_acc;
    logic        e_sat;
    n = (len == 0) ? 1 : len;
    total = 0;
    for (int i = 0; i < n; i++) total += longint'(prods[i]);
`ifdef ACC_SAT_EN
    if (total > (longint'(1) << AW) - 1) begin
      e_acc = (32'd1 << AW) - 1;
      e_sat = 1'b1;
    end else begin
      e_acc = 32'(total);
      e_sat = 1'b0;
    end
`else
    e_acc = 32'(total % (longint'(1) << AW));
    e_sat = 1'b0;
`endif
    for (int i = 0; i < n; i++) begin
      if (gapped && i > 0) begin
        in_valid = 1'b0;
        prod_i   = PW'($urandom);
        tick();
        chk("gap_cnt", 32'(cnt_o), 32'(i));
        chk("gap_out_valid", 32'(out_valid), 0);
      end
      chk("in_ready_open", 32'(in_ready), 1);
      in_valid  = 1'b1;
      prod_i    = PW'(prods[i]);
      len_i     = (i == 0) ? LW'(len) : LW'($urandom);
      out_ready = (stall == 0);
      tick();
      chk("cnt_step", 32'(cnt_o), 32'(i + 1));
      chk("out_valid_step", 32'(out_valid), 32'(i == n - 1));
    end
    in_valid = 1'b0;
    chk("acc", 32'(acc_o), e_acc);
    chk("sat", 32'(sat_o), 32'(e_sat));
    chk("in_ready_hold", 32'(in_ready), 0);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_acc", 32'(acc_o), e_acc);
      chk("stall_cnt", 32'(cnt_o), 32'(n));
      chk("stall_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    tick();
    chk("drain_out_valid", 32'(out_valid), 0);
    chk("drain_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_acc", 32'(acc_o), 0);
    chk("rst_cnt", 32'(cnt_o), 0);
    chk("rst_sat", 32'(sat_o), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    tick();
    chk("idle_out_valid", 32'(out_valid), 0);

    // basic block
    prods = {100, 200, 300, 400};
    run_block(4, 1'b0, 0);

    // length zero acts as one
    prods = {32'h1234};
    run_block(0, 1'b0, 0);

    // backpressure
    prods = {5, 7};
    run_block(2, 1'b0, 5);

    // overflow
    prods = {32'hFFFF, 32'h0002};
    run_block(2, 1'b0, 0);

    // reset mid-block
    len_i = 8;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      prod_i   = PW'($urandom);
      tick();
      chk("mid_cnt", 32'(cnt_o), 32'(i + 1));
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #2;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_acc", 32'(acc_o), 0);
    chk("mid_rst_cnt", 32'(cnt_o), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_post_out_valid", 32'(out_valid), 0);
    prods = {9};
    run_block(1, 1'b0, 0);

    // gapped input
    prods = {1, 2, 3};
    run_block(3, 1'b1, 0);

    // longest block
    prods = {};
    for (int i = 0; i < 255; i++) prods.push_back($urandom_range(0, 300));
    run_block(255, 1'b0, 1);

    // randomized blocks, some overflowing
    repeat (40) begin
      int len;
      len = $urandom_range(0, 10);
      prods = {};
      for (int i = 0; i < 10; i++)
        prods.push_back(($urandom % 3 == 0) ? 32'hFFFF - $urandom_range(0, 15) : $urandom_range(0, 32'hFFFF));
      run_block(len, 1'($urandom % 2), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
